// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the dot-product MAC engine.
//   - default parameter values for mac_dot_engine / mac_mult_stage
//   - FSM state encoding
package mac_pkg;

  localparam int DW_DEF      = 4;
  localparam int ACC_W_DEF   = 16;
  localparam int LEN_MAX_DEF = 16;
  localparam int SIGNED_DEF  = 0;
  localparam int SAT_DEF     = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_mult_stage.sv
// mac_mult_stage: stage 1 of the MAC pipeline. Registers the 2*DW-bit
// product of a and b together with a product-valid flag.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   load        : a beat is accepted this cycle; capture its product
//   flush       : drop any in-flight product
//   a, b        : operands (unsigned or two's complement per SIGNED)
//   prod_q      : registered product
//   pvld_q      : prod_q holds a product not yet folded into the accumulator
module mac_mult_stage import mac_pkg::*; #(
  parameter int DW     = DW_DEF,
  parameter int SIGNED = SIGNED_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] prod_q,
  output logic            pvld_q
);

  logic [2*DW-1:0] ax, bx, prod_d;

  // Extend to the full product width first so the low 2*DW bits of the
  // multiply are the exact product in both signed and unsigned modes.
  generate
    if (SIGNED != 0) begin : g_sext
      assign ax = {{DW{a[DW-1]}}, a};
      assign bx = {{DW{b[DW-1]}}, b};
    end else begin : g_zext
      assign ax = {{DW{1'b0}}, a};
      assign bx = {{DW{1'b0}}, b};
    end
  endgenerate

  assign prod_d = ax * bx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      pvld_q <= 1'b0;
    end else if (flush) begin
      prod_q <= '0;
      pvld_q <= 1'b0;
    end else begin
      pvld_q <= load;
      if (load) prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/mac_dot_engine.sv
// mac_dot_engine: streaming dot-product engine. Accepts (a,b) beats,
// multiplies in stage 1 (mac_mult_stage), accumulates in stage 2 with
// saturating or wrapping arithmetic, and presents the result on a
// valid/ready output handshake.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand beat handshake; a, b operands, last = final beat
//   clear                 : synchronous abort of the current vector
//   out_valid/out_ready   : result handshake; acc_out = accumulated result
//   ovf                   : sticky overflow/saturation flag for the current vector
//   count                 : beats accepted in the current vector
//   busy                  : FSM not in IDLE
module mac_dot_engine import mac_pkg::*; #(
  parameter int DW      = DW_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int LEN_MAX = LEN_MAX_DEF,
  parameter int SIGNED  = SIGNED_DEF,
  parameter int SAT     = SAT_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DW-1:0]                    a,
  input  logic [DW-1:0]                    b,
  input  logic                             last,
  input  logic                             clear,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 acc_out,
  output logic                             ovf,
  output logic [$clog2(LEN_MAX+1)-1:0]     count,
  output logic                             busy
);

  localparam int CW = $clog2(LEN_MAX+1);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              accept, beat_last;
  logic [2*DW-1:0]   prod_q;
  logic              pvld_q;

  // Gating with rst_n keeps in_ready low while reset is held even though
  // the reset state is IDLE.
  assign in_ready  = rst_n & ~clear & ((state_q == IDLE) | (state_q == ACCUM));
  assign accept    = in_valid & in_ready;
  // Reaching LEN_MAX closes the vector exactly as an explicit last would.
  assign beat_last = last | (cnt_q == CW'(LEN_MAX-1));

  mac_mult_stage #(.DW(DW), .SIGNED(SIGNED)) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .flush  (clear),
    .a      (a),
    .b      (b),
    .prod_q (prod_q),
    .pvld_q (pvld_q)
  );

  // Stage 2: one extra bit of headroom makes overflow detection exact.
  logic [ACC_W:0]   prod_x, acc_x, sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] sat_val, acc_add;

  generate
    if (SIGNED != 0) begin : g_sadd
      assign prod_x  = {{(ACC_W+1-2*DW){prod_q[2*DW-1]}}, prod_q};
      assign acc_x   = {acc_q[ACC_W-1], acc_q};
      assign sum     = acc_x + prod_x;
      // Out of range when the two top bits of the widened sum disagree.
      assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
      assign sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin : g_uadd
      assign prod_x  = {{(ACC_W+1-2*DW){1'b0}}, prod_q};
      assign acc_x   = {1'b0, acc_q};
      assign sum     = acc_x + prod_x;
      assign sum_ovf = sum[ACC_W];
      assign sat_val = {ACC_W{1'b1}};
    end
  endgenerate

  assign acc_add = (sum_ovf && (SAT != 0)) ? sat_val : sum[ACC_W-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (pvld_q) begin
      acc_d = acc_add;
      ovf_d = ovf_q | sum_ovf;
    end
    if (accept) cnt_d = cnt_q + CW'(1);

    case (state_q)
      IDLE, ACCUM: if (accept) state_d = beat_last ? DRAIN : ACCUM;
      DRAIN:       state_d = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default:     state_d = IDLE;
    endcase

    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign count     = cnt_q;

endmodule
